// File: rtl/operand_fetch_pkg.sv
// Shared issue/execute definitions: instruction field layout, widths and the operand bundle.
// Execute imports the same package so both sides agree on the bundle format.
package operand_fetch_pkg;

   localparam int DATA_W = 19;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 16;
   localparam int OPC_W  = 4;
   localparam int IMM_W  = 5;
   localparam int NREG   = 8;

   localparam int OPC_LSB  = 15;
   localparam int WREN_BIT = 14;
   localparam int RD_LSB   = 11;
   localparam int RS1_LSB  = 8;
   localparam int RS2_LSB  = 5;
   localparam int IMM_LSB  = 0;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] reg_t;

   // Field order mirrors the bit positions above, MSB first.
   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic             wr_en;
      reg_t             rd;
      reg_t             rs1;
      reg_t             rs2;
      logic [IMM_W-1:0] imm;
   } instr_t;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic             wr_en;
      reg_t             rd;
      data_t            op_a;
      data_t            op_b;
      data_t            imm;
   } bundle_t;

   function automatic data_t sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   // Same-cycle writeback wins over the register file, which still returns the old value.
   function automatic data_t bypass(input logic wb_en, input reg_t wb_reg, input data_t wb_data,
                                    input reg_t rs, input data_t rf_data);
      return (wb_en && (wb_reg == rs)) ? wb_data : rf_data;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of all operand_fetch handshake, register-file, writeback and execute-side signals.
// slave is the operand_fetch side; master is the surrounding pipeline.
interface operand_fetch_if;
   import operand_fetch_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    in_instr;
   reg_t                 rf_read_reg1;
   reg_t                 rf_read_reg2;
   data_t                rf_data1;
   data_t                rf_data2;
   logic                 wb_en;
   reg_t                 wb_reg;
   data_t                wb_data;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [OPC_W-1:0]     out_opcode;
   logic                 out_wr_en;
   reg_t                 out_rd;
   data_t                out_op_a;
   data_t                out_op_b;
   data_t                out_imm;
   logic [CNT_W-1:0]     stall_cnt;

   modport slave (
      input  in_valid, in_instr, rf_data1, rf_data2, wb_en, wb_reg, wb_data, flush, out_ready,
      output in_ready, rf_read_reg1, rf_read_reg2, out_valid, out_opcode, out_wr_en, out_rd,
             out_op_a, out_op_b, out_imm, stall_cnt
   );

   modport master (
      output in_valid, in_instr, rf_data1, rf_data2, wb_en, wb_reg, wb_data, flush, out_ready,
      input  in_ready, rf_read_reg1, rf_read_reg2, out_valid, out_opcode, out_wr_en, out_rd,
             out_op_a, out_op_b, out_imm, stall_cnt
   );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits for in-flight destinations and the resulting RAW hazard.
// Per edge: writeback clear, then flush clear, then issue set; the set wins on a collision.
module of_scoreboard
   import operand_fetch_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid_i,
   input  reg_t rs1_i,
   input  reg_t rs2_i,
   input  logic wb_en_i,
   input  reg_t wb_reg_i,
   input  logic kill_en_i,
   input  reg_t kill_reg_i,
   input  logic set_en_i,
   input  reg_t set_reg_i,
   output logic hazard_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            rs1_blk_s;
   logic            rs2_blk_s;

   // A register is only blocking if no writeback to it is arriving this cycle.
   always_comb begin
      rs1_blk_s = busy_q[rs1_i] && !(wb_en_i && (wb_reg_i == rs1_i));
      rs2_blk_s = busy_q[rs2_i] && !(wb_en_i && (wb_reg_i == rs2_i));
      hazard_o  = in_valid_i && (rs1_blk_s || rs2_blk_s);
   end

   // Next busy vector with set taking priority over both clear sources.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         busy_d[i] = (set_en_i && (set_reg_i == reg_t'(i))) ? 1'b1 :
                     ((wb_en_i && (wb_reg_i == reg_t'(i))) ||
                      (kill_en_i && (kill_reg_i == reg_t'(i)))) ? 1'b0 : busy_q[i];
      end
   end

   // Busy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= {NREG{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: decodes register fields, reads the register file with writeback bypass,
// stalls on RAW hazards and presents operands through a single valid/ready output slot.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   operand_fetch_if.slave bus
);

   instr_t           instr_s;
   logic             hazard_s;
   logic             slot_free_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             kill_en_s;
   data_t            op_a_s;
   data_t            op_b_s;
   bundle_t          slot_q;
   bundle_t          slot_d;
   logic             valid_q;
   logic             valid_d;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] stall_d;

   assign instr_s = instr_t'(bus.in_instr);

   assign bus.rf_read_reg1 = instr_s.rs1;
   assign bus.rf_read_reg2 = instr_s.rs2;

   assign slot_free_s = !valid_q || bus.out_ready;
   assign in_ready_s  = slot_free_s && !hazard_s && !bus.flush;
   assign accept_s    = bus.in_valid && in_ready_s;
   // Dropping a bundle that was going to write rd releases its reservation.
   assign kill_en_s   = bus.flush && valid_q && slot_q.wr_en;

   assign op_a_s = bypass(bus.wb_en, bus.wb_reg, bus.wb_data, instr_s.rs1, bus.rf_data1);
   assign op_b_s = bypass(bus.wb_en, bus.wb_reg, bus.wb_data, instr_s.rs2, bus.rf_data2);

   of_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (bus.in_valid),
      .rs1_i      (instr_s.rs1),
      .rs2_i      (instr_s.rs2),
      .wb_en_i    (bus.wb_en),
      .wb_reg_i   (bus.wb_reg),
      .kill_en_i  (kill_en_s),
      .kill_reg_i (slot_q.rd),
      .set_en_i   (accept_s && instr_s.wr_en),
      .set_reg_i  (instr_s.rd),
      .hazard_o   (hazard_s)
   );

   // Output slot next state: flush outranks accept, accept outranks consume.
   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept_s) begin
         valid_d       = 1'b1;
         slot_d.opcode = instr_s.opcode;
         slot_d.wr_en  = instr_s.wr_en;
         slot_d.rd     = instr_s.rd;
         slot_d.op_a   = op_a_s;
         slot_d.op_b   = op_b_s;
         slot_d.imm    = sext_imm(instr_s.imm);
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Saturating count of cycles an offered instruction is refused.
   always_comb begin
      stall_d = stall_q;
      if (bus.in_valid && !in_ready_s && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // Slot and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= '0;
         valid_q <= 1'b0;
         stall_q <= {CNT_W{1'b0}};
      end else begin
         slot_q  <= slot_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = valid_q;
   assign bus.out_opcode = slot_q.opcode;
   assign bus.out_wr_en  = slot_q.wr_en;
   assign bus.out_rd     = slot_q.rd;
   assign bus.out_op_a   = slot_q.op_a;
   assign bus.out_op_b   = slot_q.op_b;
   assign bus.out_imm    = slot_q.imm;
   assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: bypass, RAW stall, backpressure, flush, same-edge
// scoreboard update, immediate sign extension and asynchronous reset.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic        clk;
   logic        rst_n;
   int          tests;
   int          fails;
   logic [18:0] rf [8];

   operand_fetch_if ifc ();

   operand_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   assign ifc.rf_data1 = rf[ifc.rf_read_reg1];
   assign ifc.rf_data2 = rf[ifc.rf_read_reg2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [18:0] mk(input logic [3:0] opc, input logic wr, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [4:0] imm);
      return {opc, wr, rd, rs1, rs2, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 8; i++) rf[i] = 19'h00000;
      rf[1] = 19'h00005;
      rf[2] = 19'h7FFFF;
      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_instr  = 19'h00000;
      ifc.wb_en     = 1'b0;
      ifc.wb_reg    = 3'd0;
      ifc.wb_data   = 19'h00000;
      ifc.flush     = 1'b0;
      ifc.out_ready = 1'b1;

      // Reset and idle
      step();
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_op_a", 32'(ifc.out_op_a), 32'd0);
      chk("rst_stall", 32'(ifc.stall_cnt), 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("idle_out_valid", 32'(ifc.out_valid), 32'd0);

      // Basic read of r1/r2
      ifc.in_valid = 1'b1;
      ifc.in_instr = mk(4'hA, 1'b0, 3'd0, 3'd1, 3'd2, 5'd3);
      #1;
      chk("rd_reg1", 32'(ifc.rf_read_reg1), 32'd1);
      chk("rd_reg2", 32'(ifc.rf_read_reg2), 32'd2);
      chk("basic_in_ready", 32'(ifc.in_ready), 32'd1);
      step();
      chk("basic_valid", 32'(ifc.out_valid), 32'd1);
      chk("basic_op_a", 32'(ifc.out_op_a), 32'h00005);
      chk("basic_op_b", 32'(ifc.out_op_b), 32'h7FFFF);
      chk("basic_opc", 32'(ifc.out_opcode), 32'hA);
      chk("basic_imm", 32'(ifc.out_imm), 32'h00003);

      // Writer to r3 with rs1 == rs2 == r1
      ifc.in_instr = mk(4'h1, 1'b1, 3'd3, 3'd1, 3'd1, 5'd0);
      step();
      chk("wr3_rd", 32'(ifc.out_rd), 32'd3);
      chk("wr3_wren", 32'(ifc.out_wr_en), 32'd1);
      chk("wr3_op_a", 32'(ifc.out_op_a), 32'h00005);
      chk("wr3_op_b", 32'(ifc.out_op_b), 32'h00005);

      // RAW on r3
      ifc.in_instr = mk(4'h2, 1'b0, 3'd0, 3'd3, 3'd0, 5'd0);
      #1;
      chk("raw_in_ready", 32'(ifc.in_ready), 32'd0);
      step();
      chk("raw_drain", 32'(ifc.out_valid), 32'd0);
      step();
      chk("raw_stall", 32'(ifc.stall_cnt), 32'd2);
      ifc.wb_en   = 1'b1;
      ifc.wb_reg  = 3'd3;
      ifc.wb_data = 19'h12345;
      #1;
      chk("wb_in_ready", 32'(ifc.in_ready), 32'd1);
      step();
      rf[3]     = 19'h12345;
      ifc.wb_en = 1'b0;
      chk("byp_valid", 32'(ifc.out_valid), 32'd1);
      chk("byp_op_a", 32'(ifc.out_op_a), 32'h12345);
      chk("byp_stall", 32'(ifc.stall_cnt), 32'd2);

      // Backpressure for 4 cycles
      ifc.out_ready = 1'b0;
      ifc.in_instr  = mk(4'h3, 1'b0, 3'd0, 3'd2, 3'd1, 5'd0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
         step();
      end
      chk("bp_op_a", 32'(ifc.out_op_a), 32'h12345);
      chk("bp_opc", 32'(ifc.out_opcode), 32'h2);
      chk("bp_valid", 32'(ifc.out_valid), 32'd1);
      chk("bp_stall", 32'(ifc.stall_cnt), 32'd6);
      ifc.out_ready = 1'b1;
      #1;
      chk("bp_release", 32'(ifc.in_ready), 32'd1);
      step();
      chk("bp2_op_a", 32'(ifc.out_op_a), 32'h7FFFF);
      chk("bp2_op_b", 32'(ifc.out_op_b), 32'h00005);
      chk("bp2_opc", 32'(ifc.out_opcode), 32'h3);

      // Flush of an occupied slot writing r6
      ifc.in_instr = mk(4'h4, 1'b1, 3'd6, 3'd0, 3'd0, 5'd0);
      step();
      chk("fl_rd", 32'(ifc.out_rd), 32'd6);
      ifc.in_instr = mk(4'h5, 1'b0, 3'd0, 3'd6, 3'd0, 5'd0);
      ifc.flush    = 1'b1;
      #1;
      chk("fl_in_ready", 32'(ifc.in_ready), 32'd0);
      step();
      ifc.flush = 1'b0;
      chk("fl_valid", 32'(ifc.out_valid), 32'd0);
      #1;
      chk("fl_r6_free", 32'(ifc.in_ready), 32'd1);
      step();
      chk("fl_acc_valid", 32'(ifc.out_valid), 32'd1);
      chk("fl_acc_opc", 32'(ifc.out_opcode), 32'h5);
      chk("fl_stall", 32'(ifc.stall_cnt), 32'd7);

      // Same-edge clear and set of r4, negative immediate
      ifc.in_instr = mk(4'h6, 1'b1, 3'd4, 3'd0, 3'd0, 5'd0);
      step();
      ifc.in_instr = mk(4'h7, 1'b1, 3'd4, 3'd0, 3'd0, 5'b10000);
      ifc.wb_en    = 1'b1;
      ifc.wb_reg   = 3'd4;
      ifc.wb_data  = 19'h00042;
      #1;
      chk("se_in_ready", 32'(ifc.in_ready), 32'd1);
      step();
      rf[4]     = 19'h00042;
      ifc.wb_en = 1'b0;
      chk("se_imm", 32'(ifc.out_imm), 32'h7FFF0);
      chk("se_opc", 32'(ifc.out_opcode), 32'h7);
      ifc.in_instr = mk(4'h8, 1'b0, 3'd0, 3'd4, 3'd0, 5'd0);
      #1;
      chk("se_r4_busy", 32'(ifc.in_ready), 32'd0);

      // Mark r2 busy, stall on it, then async reset mid-cycle
      ifc.in_instr = mk(4'h9, 1'b1, 3'd2, 3'd0, 3'd0, 5'd0);
      step();
      ifc.in_instr = mk(4'hA, 1'b0, 3'd0, 3'd2, 3'd0, 5'd0);
      #1;
      chk("r2_in_ready", 32'(ifc.in_ready), 32'd0);
      step();
      step();
      chk("r2_stall", 32'(ifc.stall_cnt), 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(ifc.out_valid), 32'd0);
      chk("ar_rd", 32'(ifc.out_rd), 32'd0);
      chk("ar_imm", 32'(ifc.out_imm), 32'd0);
      chk("ar_stall", 32'(ifc.stall_cnt), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("ar_busy_clr", 32'(ifc.in_ready), 32'd1);
      step();
      chk("ar_acc_valid", 32'(ifc.out_valid), 32'd1);
      chk("ar_acc_op_a", 32'(ifc.out_op_a), 32'h7FFFF);
      chk("ar_acc_opc", 32'(ifc.out_opcode), 32'hA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
